// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file for the datapath.
// One synchronous write port, two independent combinational read ports.
// Every entry, including entry 0, is ordinary writable storage.
// Reads have no write-to-read bypass: a read of the write target shows
// the old value until the write edge, then the new value combinationally.
module regfile (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        ctrl_writeEn,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    input  logic [31:0] data_writeReg,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB
);

    localparam int NUM_REGS = 32;

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] write_sel;

    // Decode the write address into a one-hot strobe, gated by the enable.
    always_comb begin
        write_sel = '0;
        if (ctrl_writeEn) begin
            write_sel[ctrl_writeReg] = 1'b1;
        end
    end

    // Next-state for each entry: only the selected entry takes new data.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (write_sel[i]) begin
                regs_d[i] = data_writeReg;
            end
        end
    end

    // Storage update; reset wins over a write on the same edge.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ctrl_reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational read ports, fully independent of each other.
    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        data_readRegB = regs_q[ctrl_readRegB];
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for the 32 x 32 register file.
// A reference array tracks register contents; read expectations are
// queued when addresses are driven and popped when the ports are sampled.
module tb_regfile;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEn;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int n_vectors;
    int n_miscompares;

    regfile dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .ctrl_writeEn  (ctrl_writeEn),
        .ctrl_writeReg (ctrl_writeReg),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .data_writeReg (data_writeReg),
        .data_readRegA (data_readRegA),
        .data_readRegB (data_readRegB)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count one comparison and report it if the values differ.
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Apply one clock edge with the given controls and update the model.
    task automatic drive_edge(input logic rst, input logic en,
                              input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        ctrl_reset    = rst;
        ctrl_writeEn  = en;
        ctrl_writeReg = addr;
        data_writeReg = data;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (en) begin
            model[addr] = data;
        end
        #1;
        ctrl_reset   = 1'b0;
        ctrl_writeEn = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        drive_edge(1'b0, 1'b1, addr, data);
    endtask

    // Drive both read addresses, queue the expectations, sample and compare.
    task automatic read_check(input string tag, input logic [4:0] a,
                              input logic [4:0] b);
        exp_q.push_back(model[a]);
        exp_q.push_back(model[b]);
        ctrl_readRegA = a;
        ctrl_readRegB = b;
        #1;
        check_eq($sformatf("%s A[%0d]", tag, a), data_readRegA, exp_q.pop_front());
        check_eq($sformatf("%s B[%0d]", tag, b), data_readRegB, exp_q.pop_front());
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        ctrl_reset    = 1'b1;
        ctrl_writeEn  = 1'b0;
        ctrl_writeReg = '0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        data_writeReg = '0;

        // Reset held for two edges, then every address on both ports.
        drive_edge(1'b1, 1'b0, 5'd0, 32'h0);
        drive_edge(1'b1, 1'b0, 5'd0, 32'h0);
        for (int r = 0; r < 32; r++) begin
            exp_q.push_back(32'h0000_0000);
            exp_q.push_back(32'h0000_0000);
            ctrl_readRegA = 5'(r);
            ctrl_readRegB = 5'(31 - r);
            #1;
            check_eq("reset_a", data_readRegA, exp_q.pop_front());
            check_eq("reset_b", data_readRegB, exp_q.pop_front());
        end

        // Uniform write/readback, entry 0 included.
        for (int r = 0; r < 32; r++) begin
            do_write(5'(r), 32'h1000_DEAD);
            read_check("uniform", 5'(r), 5'(r));
        end

        // Walking one, then re-read all entries for corruption.
        for (int r = 0; r < 32; r++) begin
            do_write(5'(r), 32'h1 << r);
            read_check("walk", 5'(r), 5'(r));
        end
        for (int r = 0; r < 32; r++) begin
            exp_q.push_back(32'h1 << r);
            ctrl_readRegA = 5'(r);
            ctrl_readRegB = 5'(r);
            #1;
            check_eq("walk_reread", data_readRegA, exp_q.pop_front());
        end

        // Write-enable gating.
        do_write(5'd5, 32'hCAFE_F00D);
        for (int k = 0; k < 4; k++) drive_edge(1'b0, 1'b0, 5'd5, 32'h1234_5678);
        exp_q.push_back(32'hCAFE_F00D);
        ctrl_readRegA = 5'd5;
        #1;
        check_eq("we_gate", data_readRegA, exp_q.pop_front());

        // Dual-port independence.
        do_write(5'd3, 32'hAAAA_5555);
        do_write(5'd17, 32'h5555_AAAA);
        read_check("dual", 5'd3, 5'd17);
        read_check("same", 5'd17, 5'd17);

        // Read-during-write: old value before the edge, new value right after.
        @(negedge clock);
        ctrl_readRegA = 5'd17;
        ctrl_writeEn  = 1'b1;
        ctrl_writeReg = 5'd17;
        data_writeReg = 32'h0F0F_0F0F;
        #1;
        check_eq("rdw_before", data_readRegA, 32'h5555_AAAA);
        @(posedge clock);
        model[17] = 32'h0F0F_0F0F;
        #1;
        ctrl_writeEn = 1'b0;
        check_eq("rdw_after", data_readRegA, 32'h0F0F_0F0F);

        // Reset priority over a simultaneous write.
        do_write(5'd9, 32'h0000_0999);
        drive_edge(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF);
        for (int r = 0; r < 32; r++) read_check("rst_prio", 5'(r), 5'((r + 9) % 32));

        // Randomised traffic with occasional mid-stream resets.
        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 99);
            if (op < 3) begin
                drive_edge(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            end else if (op < 70) begin
                do_write(5'($urandom_range(0, 31)), $urandom);
            end else begin
                drive_edge(1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom);
            end
            read_check("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
